param_bus_datapath: RTL and testbench

//  Parametrised single-bus CPU datapath: NUM_REGS x WIDTH register file, PC, IR, MAR, MDR, Y, HI/LO, Z.

---
 rtl/param_bus_datapath.sv | 236 +++++++++++++++++++++++
 tb/tb_param_bus_datapath.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_bus_datapath.sv
// param_bus_datapath
//   Single-bus CPU datapath: NUM_REGS x WIDTH register file, PC, IR, MAR, MDR,
//   Y, HI, LO and a 2*WIDTH Z register fed by an ALU. The ALU has single-cycle ops
//   and iterative signed MUL/DIV (one bit per cycle, WIDTH cycles).
//
// Ports
//   Clock, Clear                 rising-edge clock, asynchronous active-low reset
//   Rout / Rin                   general-register bus drive / load enables (one bit per register)
//   HIout..MDRout                bus drive selects; priority R0..R(N-1), HI, LO, Zhigh, Zlow, PC, MDR
//   HIin..Yin                    load-from-bus enables, all sampled on the rising edge
//   IncPC                        PC <= PC + PC_STEP (PCin wins when both are set)
//   Read, Mdatain                MDR source select and memory read data
//   Op, Start                    ALU operation and strobe (A = Y, B = bus)
//   Busy, Done                   MUL/DIV running; one-cycle pulse after Z is written
//   BusErr                       two or more bus sources selected
//   BusOut, MAR_q, IR_q          bus value, MAR and IR contents
//   o_alu_state                  ALU FSM state (0 = IDLE, 1 = RUN)
//
// Handshake: Start is accepted on any rising edge where Busy=0 (including the
// cycle where Done is high) and ignored while Busy=1. Done is high for exactly
// one cycle following the edge that wrote Z.
module param_bus_datapath #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ZERO_R0  = 0,
  parameter int PC_STEP  = 1
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic [NUM_REGS-1:0] Rout,
  input  logic [NUM_REGS-1:0] Rin,
  input  logic                HIout,
  input  logic                LOout,
  input  logic                Zhighout,
  input  logic                Zlowout,
  input  logic                PCout,
  input  logic                MDRout,
  input  logic                HIin,
  input  logic                LOin,
  input  logic                PCin,
  input  logic                MDRin,
  input  logic                MARin,
  input  logic                IRin,
  input  logic                Yin,
  input  logic                IncPC,
  input  logic                Read,
  input  logic [WIDTH-1:0]    Mdatain,
  input  logic [3:0]          Op,
  input  logic                Start,
  output logic                Busy,
  output logic                Done,
  output logic                BusErr,
  output logic [WIDTH-1:0]    BusOut,
  output logic [WIDTH-1:0]    MAR_q,
  output logic [WIDTH-1:0]    IR_q,
  output logic                o_alu_state
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] PC_INC = WIDTH'(PC_STEP);
  localparam logic [3:0] OP_MUL = 4'd11;
  localparam logic [3:0] OP_DIV = 4'd12;

  typedef enum logic { S_IDLE = 1'b0, S_RUN = 1'b1 } alu_state_t;

  logic [WIDTH-1:0] r_regs [NUM_REGS];
  logic [WIDTH-1:0] r_pc, r_ir, r_mar, r_mdr, r_y, r_hi, r_lo, r_zhi, r_zlo;

  alu_state_t         r_state;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // MUL: {partial product hi, multiplier}; DIV: {remainder, quotient}
  logic [WIDTH-1:0]   r_mc;      // multiplicand / divisor magnitude
  logic [WIDTH-1:0]   r_a;       // original dividend, returned as Zhigh on divide by zero
  logic               r_is_div, r_neg_q, r_neg_r, r_div0, r_done;

  logic [WIDTH-1:0]          w_bus, w_res, w_a_mag, w_b_mag;
  logic [NUM_REGS+5:0]       w_src;
  logic [SW-1:0]             w_sh;
  logic [WIDTH:0]            w_sum, w_shift, w_trial;
  logic [2*WIDTH-1:0]        w_mul_next, w_div_next, w_next, w_prod;
  logic [WIDTH-1:0]          w_quo, w_rem;

  // Bus mux: later assignments override earlier ones, so R0 ends up highest priority.
  always_comb begin
    w_bus = '0;
    if (MDRout)   w_bus = r_mdr;
    if (PCout)    w_bus = r_pc;
    if (Zlowout)  w_bus = r_zlo;
    if (Zhighout) w_bus = r_zhi;
    if (LOout)    w_bus = r_lo;
    if (HIout)    w_bus = r_hi;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (Rout[i]) w_bus = ((ZERO_R0 != 0) && (i == 0)) ? '0 : r_regs[i];
    end
  end

  assign w_src  = {MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout};
  assign BusErr = ($countones(w_src) > 1);
  assign BusOut = w_bus;
  assign MAR_q  = r_mar;
  assign IR_q   = r_ir;
  assign Busy   = (r_state == S_RUN);
  assign Done   = r_done;
  assign o_alu_state = r_state;

  // Single-cycle ALU
  assign w_sh = w_bus[SW-1:0];
  always_comb begin
    w_res = '0;
    case (Op)
      4'd0:    w_res = r_y + w_bus;
      4'd1:    w_res = r_y - w_bus;
      4'd2:    w_res = r_y & w_bus;
      4'd3:    w_res = r_y | w_bus;
      4'd4:    w_res = r_y >> w_sh;
      4'd5:    w_res = $signed(r_y) >>> w_sh;
      4'd6:    w_res = r_y << w_sh;
      4'd7:    w_res = (r_y >> w_sh) | (r_y << (WIDTH - w_sh));  // shift by WIDTH yields 0
      4'd8:    w_res = (r_y << w_sh) | (r_y >> (WIDTH - w_sh));
      4'd9:    w_res = -w_bus;
      4'd10:   w_res = ~w_bus;
      default: w_res = '0;
    endcase
  end

  // Iterative MUL/DIV work on magnitudes; signs are restored when Z is written.
  assign w_a_mag = r_y[WIDTH-1]   ? -r_y   : r_y;
  assign w_b_mag = w_bus[WIDTH-1] ? -w_bus : w_bus;

  // Shift-add multiply step
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mc} : '0);
  assign w_mul_next = {w_sum, r_acc[WIDTH-1:1]};

  // Restoring divide step: shift in next dividend bit, subtract if it fits
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_trial    = w_shift - {1'b0, r_mc};
  assign w_div_next = w_trial[WIDTH] ? {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_next = r_is_div ? w_div_next : w_mul_next;
  assign w_prod = r_neg_q ? -w_next : w_next;
  assign w_quo  = r_neg_q ? -w_next[WIDTH-1:0] : w_next[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -w_next[2*WIDTH-1:WIDTH] : w_next[2*WIDTH-1:WIDTH];

  // Register file and bus-loaded registers
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_pc  <= '0;
      r_ir  <= '0;
      r_mar <= '0;
      r_mdr <= '0;
      r_y   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (Rin[i] && !((ZERO_R0 != 0) && (i == 0))) r_regs[i] <= w_bus;
      end
      if (PCin)       r_pc <= w_bus;
      else if (IncPC) r_pc <= r_pc + PC_INC;
      if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
      if (MARin) r_mar <= w_bus;
      if (IRin)  r_ir  <= w_bus;
      if (Yin)   r_y   <= w_bus;
      if (HIin)  r_hi  <= w_bus;
      if (LOin)  r_lo  <= w_bus;
    end
  end

  // ALU FSM and Z
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mc     <= '0;
      r_a      <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_zhi    <= '0;
      r_zlo    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            if (Op == OP_MUL || Op == OP_DIV) begin
              r_state  <= S_RUN;
              r_cnt    <= '0;
              r_is_div <= (Op == OP_DIV);
              r_neg_q  <= r_y[WIDTH-1] ^ w_bus[WIDTH-1];
              r_neg_r  <= r_y[WIDTH-1];
              r_div0   <= (w_bus == '0);
              r_a      <= r_y;
              if (Op == OP_MUL) begin
                r_acc <= {{WIDTH{1'b0}}, w_b_mag};
                r_mc  <= w_a_mag;
              end else begin
                r_acc <= {{WIDTH{1'b0}}, w_a_mag};
                r_mc  <= w_b_mag;
              end
            end else begin
              r_zhi  <= '0;
              r_zlo  <= w_res;
              r_done <= 1'b1;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(WIDTH - 1)) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
            if (!r_is_div) begin
              {r_zhi, r_zlo} <= w_prod;
            end else if (r_div0) begin
              r_zhi <= r_a;
              r_zlo <= '1;
            end else begin
              r_zhi <= w_rem;
              r_zlo <= w_quo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_param_bus_datapath.sv
// Testbench for param_bus_datapath (WIDTH=32, NUM_REGS=16).
module tb_param_bus_datapath;
  localparam int W = 32;
  localparam int N = 16;
  localparam logic [5:0] SEL_HI = 6'b100000, SEL_LO = 6'b010000, SEL_ZH = 6'b001000,
                         SEL_ZL = 6'b000100, SEL_PC = 6'b000010, SEL_MDR = 6'b000001;
  // load selects {HIin, LOin, PCin, MARin, IRin, Yin}
  localparam logic [5:0] LD_HI = 6'b100000, LD_LO = 6'b010000, LD_PC = 6'b001000,
                         LD_MAR = 6'b000100, LD_IR = 6'b000010, LD_Y = 6'b000001;

  logic Clock, Clear;
  logic [N-1:0] Rout, Rin;
  logic HIout, LOout, Zhighout, Zlowout, PCout, MDRout;
  logic HIin, LOin, PCin, MDRin, MARin, IRin, Yin, IncPC, Read, Start;
  logic [W-1:0] Mdatain;
  logic [3:0] Op;
  logic Busy, Done, BusErr, alu_state;
  logic [W-1:0] BusOut, MAR_q, IR_q;

  param_bus_datapath #(.WIDTH(W), .NUM_REGS(N), .ZERO_R0(0), .PC_STEP(1)) dut (
    .Clock(Clock), .Clear(Clear), .Rout(Rout), .Rin(Rin),
    .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCout(PCout), .MDRout(MDRout), .HIin(HIin), .LOin(LOin), .PCin(PCin),
    .MDRin(MDRin), .MARin(MARin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC),
    .Read(Read), .Mdatain(Mdatain), .Op(Op), .Start(Start), .Busy(Busy),
    .Done(Done), .BusErr(BusErr), .BusOut(BusOut), .MAR_q(MAR_q), .IR_q(IR_q),
    .o_alu_state(alu_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [W-1:0]  exp_q[$];
  logic          err_q[$];
  string         name_q[$];
  logic [63:0]   done_q[$];
  logic          obs = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: bus observations and Done pulses, sampled on the falling edge.
  always @(negedge Clock) begin
    if (obs) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL obs_queue: bus %h observed with no expectation", BusOut);
      end else begin
        string nm;
        logic [W-1:0] e;
        logic ee;
        nm = name_q.pop_front();
        e  = exp_q.pop_front();
        ee = err_q.pop_front();
        check(nm, BusOut, e);
        check({nm, "_buserr"}, BusErr, ee);
      end
    end
    if (Done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL done_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        check("done_cycle", cyc, done_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic mdr_load(input logic [W-1:0] v);
    Read = 1'b1; MDRin = 1'b1; Mdatain = v;
    step();
    Read = 1'b0; MDRin = 1'b0; Mdatain = '0;
  endtask

  task automatic load_misc(input logic [W-1:0] v, input logic [5:0] ins);
    mdr_load(v);
    MDRout = 1'b1;
    {HIin, LOin, PCin, MARin, IRin, Yin} = ins;
    step();
    MDRout = 1'b0;
    {HIin, LOin, PCin, MARin, IRin, Yin} = '0;
  endtask

  task automatic reg_load(input int k, input logic [W-1:0] v);
    mdr_load(v);
    MDRout = 1'b1; Rin = '0; Rin[k] = 1'b1;
    step();
    MDRout = 1'b0; Rin = '0;
  endtask

  task automatic observe(input string name, input logic [N-1:0] rsel, input logic [5:0] msel,
                         input logic [W-1:0] exp, input logic exp_err);
    Rout = rsel;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout} = msel;
    name_q.push_back(name); exp_q.push_back(exp); err_q.push_back(exp_err);
    obs = 1'b1;
    step();
    obs = 1'b0;
    Rout = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout} = '0;
  endtask

  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    load_misc(a, LD_Y);
    mdr_load(b);
    MDRout = 1'b1; Op = op; Start = 1'b1;
    done_q.push_back(64'(cyc) + ((op == 4'd11 || op == 4'd12) ? 64'(W + 1) : 64'd1));
    step();
    MDRout = 1'b0; Op = '0; Start = 1'b0;
  endtask

  task automatic wait_busy(input string name, input logic mid_start);
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      if (mid_start && n == 5) begin
        Start = 1'b1; Op = 4'd0; MDRout = 1'b1;
      end
      step();
      Start = 1'b0; Op = '0; MDRout = 1'b0;
      n++;
    end
    check({name, "_busy_cycles"}, n, W);
  endtask

  task automatic long_op(input string name, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                         input logic mid_start);
    start_op(op, a, b);
    wait_busy(name, mid_start);
    observe({name, "_zlo"}, '0, SEL_ZL, elo, 1'b0);
    observe({name, "_zhi"}, '0, SEL_ZH, ehi, 1'b0);
  endtask

  typedef struct packed {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
  } vec_t;
  vec_t vecs [0:14];

  // ---------------- main sequence ----------------
  initial begin
    Clear = 1'b1; Rout = '0; Rin = '0;
    {HIout, LOout, Zhighout, Zlowout, PCout, MDRout} = '0;
    {HIin, LOin, PCin, MARin, IRin, Yin} = '0;
    MDRin = 0; IncPC = 0; Read = 0; Start = 0; Mdatain = '0; Op = '0;
    vecs = '{
      '{4'd0,  32'h0000_0007, 32'hFFFF_FFFD, 32'h0000_0004},
      '{4'd1,  32'h0000_0005, 32'h0000_0009, 32'hFFFF_FFFC},
      '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000},
      '{4'd3,  32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F},
      '{4'd4,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
      '{4'd5,  32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
      '{4'd6,  32'h0000_0001, 32'h0000_0021, 32'h0000_0002},
      '{4'd7,  32'h0000_0001, 32'h0000_0001, 32'h8000_0000},
      '{4'd8,  32'h8000_0001, 32'h0000_0004, 32'h0000_0018},
      '{4'd7,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678},
      '{4'd9,  32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFB},
      '{4'd10, 32'h0000_0000, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
      '{4'd13, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000},
      '{4'd15, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000},
      '{4'd0,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000}
    };
    #2 Clear = 1'b0;
    #10;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_bus", BusOut, 0);
    check("rst_mar", MAR_q, 0);
    check("rst_ir", IR_q, 0);
    step();
    Clear = 1'b1;
    step();

    // bus and registers
    reg_load(3, 32'h0000_1234);
    observe("r3", 16'h0008, '0, 32'h0000_1234, 1'b0);
    Rout = 16'h0008; Rin = 16'h0020;
    step();
    Rout = '0; Rin = '0;
    observe("r5", 16'h0020, '0, 32'h0000_1234, 1'b0);
    load_misc(32'h0000_0055, LD_PC);
    observe("r3_pc_conflict", 16'h0008, SEL_PC, 32'h0000_1234, 1'b1);
    observe("pc", '0, SEL_PC, 32'h0000_0055, 1'b0);
    load_misc(32'h0000_CAFE, LD_HI);
    load_misc(32'h0000_BEEF, LD_LO);
    observe("lo", '0, SEL_LO, 32'h0000_BEEF, 1'b0);
    observe("hi_lo_conflict", '0, SEL_HI | SEL_LO, 32'h0000_CAFE, 1'b1);
    observe("none", '0, '0, 32'h0, 1'b0);

    // MUL / DIV
    long_op("mul_m5x6", 4'd11, 32'hFFFF_FFFB, 32'h0000_0006, 32'hFFFF_FFFF, 32'hFFFF_FFE2, 1'b1);
    start_op(4'd11, 32'hFFFF_FFFB, 32'h0000_0006);
    wait_busy("mul_chain", 1'b0);
    // Done is high now; a Start on this edge must be accepted
    MDRout = 1'b1; Op = 4'd0; Start = 1'b1;
    done_q.push_back(64'(cyc) + 64'd1);
    step();
    MDRout = 1'b0; Op = '0; Start = 1'b0;
    observe("chain_add_zlo", '0, SEL_ZL, 32'h0000_0001, 1'b0);
    observe("chain_add_zhi", '0, SEL_ZH, 32'h0000_0000, 1'b0);
    long_op("mul_min_x_m1", 4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);
    long_op("mul_max_sq", 4'd11, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0);
    observe("hi_untouched", '0, SEL_HI, 32'h0000_CAFE, 1'b0);
    long_op("div_m7_2", 4'd12, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    long_op("div_9_0", 4'd12, 32'h0000_0009, 32'h0000_0000, 32'h0000_0009, 32'hFFFF_FFFF, 1'b0);
    long_op("div_7_m2", 4'd12, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
    long_op("div_m8_m3", 4'd12, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 1'b0);

    // single-cycle ALU vectors
    for (int i = 0; i < 15; i++) begin
      start_op(vecs[i].op, vecs[i].a, vecs[i].b);
      observe($sformatf("alu%0d_zlo", i), '0, SEL_ZL, vecs[i].r, 1'b0);
      observe($sformatf("alu%0d_zhi", i), '0, SEL_ZH, 32'h0, 1'b0);
    end

    // PC / MDR / MAR / IR
    load_misc(32'hFFFF_FFFF, LD_PC);
    IncPC = 1'b1; step(); IncPC = 1'b0;
    observe("pc_wrap", '0, SEL_PC, 32'h0, 1'b0);
    mdr_load(32'h0000_0100);
    MDRout = 1'b1; PCin = 1'b1; IncPC = 1'b1;
    step();
    MDRout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
    observe("pc_pcin_wins", '0, SEL_PC, 32'h0000_0100, 1'b0);
    IncPC = 1'b1; step(); IncPC = 1'b0;
    observe("pc_inc", '0, SEL_PC, 32'h0000_0101, 1'b0);
    mdr_load(32'hA5A5_A5A5);
    observe("mdr_read", '0, SEL_MDR, 32'hA5A5_A5A5, 1'b0);
    Rout = 16'h0008; MDRin = 1'b1; Read = 1'b0;
    step();
    Rout = '0; MDRin = 1'b0;
    observe("mdr_from_bus", '0, SEL_MDR, 32'h0000_1234, 1'b0);
    load_misc(32'hDEAD_0001, LD_MAR | LD_IR);
    check("mar", MAR_q, 32'hDEAD_0001);
    check("ir", IR_q, 32'hDEAD_0001);

    // reset in the middle of a MUL
    load_misc(32'h0000_0003, LD_Y);
    mdr_load(32'h0000_0004);
    MDRout = 1'b1; Op = 4'd11; Start = 1'b1;
    step();
    MDRout = 1'b0; Op = '0; Start = 1'b0;
    step(); step(); step();
    check("midmul_busy", Busy, 1);
    #1 Clear = 1'b0;
    #1;
    check("midrst_busy", Busy, 0);
    check("midrst_done", Done, 0);
    check("midrst_mar", MAR_q, 0);
    check("midrst_ir", IR_q, 0);
    step();
    Clear = 1'b1;
    observe("midrst_r3", 16'h0008, '0, 32'h0, 1'b0);
    observe("midrst_r5", 16'h0020, '0, 32'h0, 1'b0);
    observe("midrst_pc", '0, SEL_PC, 32'h0, 1'b0);
    observe("midrst_mdr", '0, SEL_MDR, 32'h0, 1'b0);
    observe("midrst_hi", '0, SEL_HI, 32'h0, 1'b0);
    observe("midrst_lo", '0, SEL_LO, 32'h0, 1'b0);
    observe("midrst_zlo", '0, SEL_ZL, 32'h0, 1'b0);
    observe("midrst_zhi", '0, SEL_ZH, 32'h0, 1'b0);
    // Y must be 0: 0 + 5 = 5
    mdr_load(32'h0000_0005);
    MDRout = 1'b1; Op = 4'd0; Start = 1'b1;
    done_q.push_back(64'(cyc) + 64'd1);
    step();
    MDRout = 1'b0; Op = '0; Start = 1'b0;
    observe("midrst_y_zero", '0, SEL_ZL, 32'h0000_0005, 1'b0);

    repeat (40) step();
    check("done_q_drained", done_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
